alsu_req_arbiter: RTL and testbench
===================================

Name: alsu_req_arbiter

Overview:
- Shares one ALSU instance between two requesters (req0, req1) through valid/ready command ports.
- Arbitrates round-robin every cycle and drives the ALSU input pins directly. The ALSU is fully pipelined, so one operation can issue per cycle.
- Tracks each in-flight op with a 2-deep tag pipeline and returns the ALSU result to the requester that owns it.
- A lock mechanism keeps back-to-back shift/rotate chains from one requester unbroken.

Parameters:
- LOCK_TIMEOUT, default 8: consecutive owner-idle cycles after which a lock is released.
- PRIORITY_REQ, default 0: requester treated as "not last granted" after reset.
- ALSU_LATENCY, default 2: cycles from issue to result. Fixed by the ALSU; only 2 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_cmd  in  16  command. Fields: [15:13] opcode, [12:10] A (signed), [9:7] B (signed), [6] cin, [5] red_op_A, [4] red_op_B, [3] bypass_A, [2] bypass_B, [1] direction, [0] serial_in.
- req0_lock  in  1  hold the grant after this command.
- req1_valid, req1_ready, req1_cmd, req1_lock: same as requester 0.
- alsu_opcode  out  3  to ALSU.
- alsu_A, alsu_B  out  3 each  to ALSU, signed.
- alsu_cin, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction, alsu_serial_in  out  1 each  to ALSU.
- alsu_out  in  6  ALSU result, signed.
- rsp0_valid  out  1  result for requester 0 valid this cycle.
- rsp1_valid  out  1  result for requester 1 valid this cycle.
- rsp_out  out  6  equals alsu_out.
- rsp_invalid  out  1  the returned op was an invalid ALSU op.
- lock_state  out  2  {locked, owner}.

Behaviour:
- Reset: asynchronous and active-high.
  - Lock state is UNLOCKED; timeout counter is 0; tag pipeline is empty.
  - last_grant is set to ~PRIORITY_REQ.
  - All outputs are 0; ALSU pins carry the NOP.
- NOP: all ALSU pins 0 (opcode 0, A=B=0). It is driven in every cycle with no grant.
- Grant is combinational in cycle t:
  - UNLOCKED, one requester valid: grant that requester.
  - UNLOCKED, both valid: grant the requester that is not last_grant.
  - LOCKED_i: only requester i is eligible; the other requester's ready is 0.
  - reqN_ready = grantN. Ready may depend on valid.
- Accept (valid & ready) in cycle t:
  - The command fields drive the ALSU pins in cycle t; the ALSU captures them at the end of t.
  - last_grant updates to the granted requester.
- Tag pipeline: stage1 ← {accept, requester id, inv}; stage2 ← stage1.
  - inv = ((red_op_A | red_op_B) & (opcode[1] | opcode[2])) | (opcode[1] & opcode[2]).
  - In cycle t+2: rspN_valid = stage2 valid & id==N, and rsp_invalid = stage2.inv.
  - rsp_invalid is 0 whenever no response is valid.
  - Responses are single-cycle pulses with no backpressure.
- Lock state machine (UNLOCKED, LOCKED_0, LOCKED_1):
  - An accept with lock=1 from requester i goes to LOCKED_i.
  - An accept by the owner with lock=0 goes to UNLOCKED after that op.
  - In LOCKED_i, the counter increments each cycle req_i_valid=0 and clears on owner valid.
  - When the counter reaches LOCK_TIMEOUT, go to UNLOCKED and clear the counter.
- Shift/rotate ops (opcodes 4, 5) operate on the ALSU out from the previous cycle:
  - Chaining is correct only for back-to-back accepts.
  - After a NOP cycle, the previous out is 0.
- Reset mid-flight: in-flight tags are dropped and no responses occur for them. The first grant after release follows PRIORITY_REQ.

Test Plan:
- req0 cmd opcode=2, A=3, B=2, cin=0, idle otherwise, accepted at t -> rsp0_valid=1 at t+2 only, rsp_out=6'd5, rsp_invalid=0, rsp1_valid=0.
- Both requesters hold valid with lock=0 for 6 cycles after reset -> grants 0,1,0,1,0,1; rspN_valid follows the same sequence delayed by 2 cycles.
- Ops preceded by a NOP cycle; req0 lock=1 sends opcode=4, direction=1, serial_in=1 for 3 back-to-back cycles while req1_valid=1; the 4th req0 op has lock=0 -> req1_ready=0 during the burst; rsp_out = 000001, 000011, 000111; req1 is granted the cycle after the lock=0 accept.
- req0 accepted with lock=1, then req0_valid=0 and req1_valid=1 -> req1_ready=0 for 8 cycles; granted on the 9th; lock_state reads 2'b00 afterwards.
- Invalid-op checks:
  - req1 opcode=6 -> rsp1 with rsp_out=0, rsp_invalid=1.
  - opcode=2 with red_op_A=1 -> rsp_out=0, rsp_invalid=1.
  - Same op with bypass_A=1, A=-2 -> rsp_out=6'b111110, rsp_invalid=1.
- req0 accepted at t, rst pulsed in t+1 -> no rsp at t+2; lock cleared; after release with both valid, the first grant goes to req0.

Source files
------------

// File: rtl/alsu_req_arbiter_if.sv
// alsu_req_arbiter_if: requester command ports, ALSU pins and response bus of the ALSU arbiter.
interface alsu_req_arbiter_if;
   logic              req0_valid, req0_ready, req0_lock;
   logic [15:0]       req0_cmd;
   logic              req1_valid, req1_ready, req1_lock;
   logic [15:0]       req1_cmd;
   logic [2:0]        alsu_opcode;
   logic signed [2:0] alsu_A, alsu_B;
   logic              alsu_cin, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
   logic              alsu_direction, alsu_serial_in;
   logic signed [5:0] alsu_out;
   logic              rsp0_valid, rsp1_valid, rsp_invalid;
   logic signed [5:0] rsp_out;
   logic [1:0]        lock_state;
   modport slave (
      input  req0_valid, req0_cmd, req0_lock, req1_valid, req1_cmd, req1_lock, alsu_out,
      output req0_ready, req1_ready, alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_red_op_A,
             alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction, alsu_serial_in,
             rsp0_valid, rsp1_valid, rsp_out, rsp_invalid, lock_state
   );
   modport master (
      output req0_valid, req0_cmd, req0_lock, req1_valid, req1_cmd, req1_lock, alsu_out,
      input  req0_ready, req1_ready, alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_red_op_A,
             alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction, alsu_serial_in,
             rsp0_valid, rsp1_valid, rsp_out, rsp_invalid, lock_state
   );
endinterface

// File: rtl/alsu_req_arbiter.sv
// alsu_req_arbiter: round-robin sharing of one pipelined ALSU between two requesters, with grant locking.
module alsu_req_arbiter #(
   parameter int LOCK_TIMEOUT = 8,
   parameter bit PRIORITY_REQ = 1'b0,
   parameter int ALSU_LATENCY = 2
) (
   input logic               clk,
   input logic               rst,
   alsu_req_arbiter_if.slave bus
);
   localparam int CW = $clog2(LOCK_TIMEOUT + 1);
   typedef enum logic [1:0] {UNLOCKED, LOCKED_0, LOCKED_1} lock_e;
   lock_e         state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_q, last_d;
   logic [2:0]    tag1_q, tag1_d, tag2_q;
   logic          elig0, elig1, gnt0, gnt1, lock_req, owner_valid;
   logic [15:0]   cmd;
   if (ALSU_LATENCY != 2) begin : g_lat
      $error("alsu_req_arbiter only supports ALSU_LATENCY == 2");
   end
   // tag = {valid, requester id, invalid-op}; stage 2 lines up with the ALSU result
   always_comb begin
      elig0       = bus.req0_valid & (state_q != LOCKED_1);
      elig1       = bus.req1_valid & (state_q != LOCKED_0);
      gnt0        = ~rst & elig0 & (~elig1 | last_q);
      gnt1        = ~rst & elig1 & (~elig0 | ~last_q);
      cmd         = gnt1 ? bus.req1_cmd : gnt0 ? bus.req0_cmd : 16'h0;
      lock_req    = gnt1 ? bus.req1_lock : bus.req0_lock;
      owner_valid = (state_q == LOCKED_1) ? bus.req1_valid : bus.req0_valid;
      tag1_d      = {gnt0 | gnt1, gnt1, ((cmd[5] | cmd[4]) & (cmd[14] | cmd[15])) | (cmd[14] & cmd[15])};
      last_d      = (gnt0 | gnt1) ? gnt1 : last_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      if (gnt0 | gnt1) begin
         state_d = ~lock_req ? UNLOCKED : gnt1 ? LOCKED_1 : LOCKED_0;
         cnt_d   = '0;
      end else if (state_q != UNLOCKED) begin
         cnt_d = owner_valid ? '0 : cnt_q + CW'(1);
         if (cnt_d == CW'(LOCK_TIMEOUT)) begin
            state_d = UNLOCKED;
            cnt_d   = '0;
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= UNLOCKED;
         cnt_q   <= '0;
         last_q  <= ~PRIORITY_REQ;
         tag1_q  <= '0;
         tag2_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         tag1_q  <= tag1_d;
         tag2_q  <= tag1_q;
      end
   end
   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;
   assign {bus.alsu_opcode, bus.alsu_A, bus.alsu_B, bus.alsu_cin, bus.alsu_red_op_A, bus.alsu_red_op_B,
           bus.alsu_bypass_A, bus.alsu_bypass_B, bus.alsu_direction, bus.alsu_serial_in} = cmd;
   assign bus.rsp0_valid  = tag2_q[2] & ~tag2_q[1];
   assign bus.rsp1_valid  = tag2_q[2] & tag2_q[1];
   assign bus.rsp_invalid = tag2_q[2] & tag2_q[0];
   assign bus.rsp_out     = bus.alsu_out;
   assign bus.lock_state  = {state_q != UNLOCKED, state_q == LOCKED_1};
endmodule

// File: tb/tb_alsu_req_arbiter.sv
// tb_alsu_req_arbiter: directed and random checks of the arbiter against a rule-level reference model.
module tb_alsu_req_arbiter;
   localparam int LT = 8;
   typedef struct packed {logic v; logic id; logic inv; logic [5:0] val;} exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   alsu_req_arbiter_if bus();
   alsu_req_arbiter #(.LOCK_TIMEOUT(LT), .PRIORITY_REQ(1'b0), .ALSU_LATENCY(2)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   logic [15:0] pins, stub_in;
   logic [5:0]  stub_out;
   int          n_chk = 0, n_fail = 0;
   int          m_owner, m_idle, m_last;
   logic [5:0]  m_prev;
   exp_t        q[$];
   logic        o_rdy0, o_rdy1, o_rsp0, o_rsp1, o_inv;
   logic [5:0]  o_out;
   logic [1:0]  o_lock;
   assign pins = {bus.alsu_opcode, bus.alsu_A, bus.alsu_B, bus.alsu_cin, bus.alsu_red_op_A, bus.alsu_red_op_B,
                  bus.alsu_bypass_A, bus.alsu_bypass_B, bus.alsu_direction, bus.alsu_serial_in};
   function automatic logic is_inv(input logic [15:0] c);
      return ((c[5] | c[4]) & (c[14] | c[15])) | (c[14] & c[15]);
   endfunction
   // behavioural ALSU: bypass wins, invalid ops give 0, shift/rotate act on the previous result
   function automatic logic [5:0] alsu_fn(input logic [15:0] c, input logic [5:0] prev);
      logic [2:0] a, b;
      logic [5:0] sa, sb;
      a  = c[12:10];
      b  = c[9:7];
      sa = {{3{a[2]}}, a};
      sb = {{3{b[2]}}, b};
      if (c[3]) return sa;
      if (c[2]) return sb;
      if (is_inv(c)) return 6'd0;
      case (c[15:13])
         3'd0:    return c[5] ? {5'd0, &a} : c[4] ? {5'd0, &b} : sa & sb;
         3'd1:    return c[5] ? {5'd0, ^a} : c[4] ? {5'd0, ^b} : sa ^ sb;
         3'd2:    return sa + sb + {5'd0, c[6]};
         3'd3:    return 6'(sa * sb);
         3'd4:    return c[1] ? {prev[4:0], c[0]} : {c[0], prev[5:1]};
         default: return c[1] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
      endcase
   endfunction
   function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                      input logic cin, input logic ra, input logic rb, input logic ba,
                                      input logic bb, input logic dir, input logic si);
      return {op, a, b, cin, ra, rb, ba, bb, dir, si};
   endfunction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stub_in  <= '0;
         stub_out <= '0;
      end else begin
         stub_in  <= pins;
         stub_out <= alsu_fn(stub_in, stub_out);
      end
   end
   assign bus.alsu_out = stub_out;
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      m_owner = -1;
      m_idle  = 0;
      m_last  = 1;
      m_prev  = '0;
      q.delete();
   endtask
   // one clock cycle, entered and left at a falling edge
   task automatic cyc(input logic v0, input logic [15:0] c0, input logic l0,
                      input logic v1, input logic [15:0] c1, input logic l1);
      int          g;
      logic        e0, e1;
      logic [15:0] gc;
      exp_t        e, x;
      bus.req0_valid = v0; bus.req0_cmd = c0; bus.req0_lock = l0;
      bus.req1_valid = v1; bus.req1_cmd = c1; bus.req1_lock = l1;
      #1;
      e0 = v0 && m_owner != 1;
      e1 = v1 && m_owner != 0;
      g  = (e0 && e1) ? (m_last == 0 ? 1 : 0) : e0 ? 0 : e1 ? 1 : -1;
      gc = (g == 0) ? c0 : (g == 1) ? c1 : 16'h0;
      e.v   = g >= 0;
      e.id  = g == 1;
      e.inv = e.v && is_inv(gc);
      e.val = alsu_fn(gc, m_prev);
      m_prev = e.val;
      q.push_back(e);
      x = (q.size() == 3) ? q.pop_front() : '0;
      o_rdy0 = bus.req0_ready; o_rdy1 = bus.req1_ready; o_rsp0 = bus.rsp0_valid; o_rsp1 = bus.rsp1_valid;
      o_inv  = bus.rsp_invalid; o_out = bus.rsp_out; o_lock = bus.lock_state;
      chk("req0_ready", 16'(o_rdy0), 16'(g == 0));
      chk("req1_ready", 16'(o_rdy1), 16'(g == 1));
      chk("alsu_pins", pins, gc);
      chk("rsp0_valid", 16'(o_rsp0), 16'(x.v && !x.id));
      chk("rsp1_valid", 16'(o_rsp1), 16'(x.v && x.id));
      chk("rsp_invalid", 16'(o_inv), 16'(x.v && x.inv));
      chk("rsp_out", 16'(o_out), 16'(x.val));
      chk("lock_state", 16'(o_lock), m_owner < 0 ? 16'd0 : m_owner == 1 ? 16'd3 : 16'd2);
      if (g >= 0) begin
         m_last  = g;
         m_owner = ((g == 0) ? l0 : l1) ? g : -1;
         m_idle  = 0;
      end else if (m_owner >= 0) begin
         if ((m_owner == 1) ? v1 : v0) m_idle = 0;
         else begin
            m_idle++;
            if (m_idle == LT) begin
               m_owner = -1;
               m_idle  = 0;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic idle();
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
   endtask
   // asserted at a falling edge, held over one rising edge, released at the next falling edge
   task automatic do_reset();
      rst = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_cmd = 16'($urandom); bus.req0_lock = 1'b1;
      bus.req1_valid = 1'b1; bus.req1_cmd = 16'($urandom); bus.req1_lock = 1'b1;
      #1;
      chk("rst_ready", {14'd0, bus.req1_ready, bus.req0_ready}, 16'd0);
      chk("rst_rsp", {13'd0, bus.rsp1_valid, bus.rsp0_valid, bus.rsp_invalid}, 16'd0);
      chk("rst_lock", 16'(bus.lock_state), 16'd0);
      chk("rst_pins", pins, 16'd0);
      chk("rst_out", 16'(bus.rsp_out), 16'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      model_reset();
   endtask
   initial begin
      logic [15:0] sh;
      logic [15:0] iv[3];
      int          p;
      model_reset();
      bus.req0_valid = 1'b0; bus.req0_cmd = '0; bus.req0_lock = 1'b0;
      bus.req1_valid = 1'b0; bus.req1_cmd = '0; bus.req1_lock = 1'b0;
      @(negedge clk);
      do_reset();
      cyc(1'b1, mk(3'd2, 3'd3, 3'd2, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 16'h0, 1'b0);
      chk("A_accept", 16'(o_rdy0), 16'd1);
      idle();
      chk("A_early", 16'(o_rsp0), 16'd0);
      idle();
      chk("A_rsp", {13'd0, o_rsp1, o_rsp0, o_inv}, 16'b010);
      chk("A_out", 16'(o_out), 16'd5);
      idle();
      chk("A_once", 16'(o_rsp0), 16'd0);
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 16'($urandom), 1'b0, 1'b1, 16'($urandom), 1'b0);
         chk("B_rr", {14'd0, o_rdy1, o_rdy0}, (i % 2 == 0) ? 16'b01 : 16'b10);
      end
      idle();
      idle();
      do_reset();
      idle();
      sh = mk(3'd4, 3'd0, 3'd0, 0, 0, 0, 0, 0, 1, 1);
      for (int k = 0; k < 7; k++) begin
         cyc(k < 4, sh, k < 3, k <= 4, mk(3'd2, 3'd1, 3'd1, 0, 0, 0, 0, 0, 0, 0), 1'b0);
         if (k < 4) chk("C_locked_out", 16'(o_rdy1), 16'd0);
         if (k == 4) chk("C_release", 16'(o_rdy1), 16'd1);
         if (k >= 2 && k <= 4) chk("C_chain", 16'(o_out), (k == 2) ? 16'h01 : (k == 3) ? 16'h03 : 16'h07);
      end
      do_reset();
      cyc(1'b1, mk(3'd0, 3'd1, 3'd1, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'($urandom), 1'b0);
         chk("D_timeout", 16'(o_rdy1), 16'(i == 8));
      end
      idle();
      chk("D_unlocked", 16'(o_lock), 16'd0);
      idle();
      do_reset();
      iv[0] = mk(3'd6, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0, 0);
      iv[1] = mk(3'd2, 3'd3, 3'd2, 0, 1, 0, 0, 0, 0, 0);
      iv[2] = mk(3'd2, 3'b110, 3'd2, 0, 1, 0, 1, 0, 0, 0);
      cyc(1'b0, 16'h0, 1'b0, 1'b1, iv[0], 1'b0);
      cyc(1'b1, iv[1], 1'b0, 1'b0, 16'h0, 1'b0);
      cyc(1'b1, iv[2], 1'b0, 1'b0, 16'h0, 1'b0);
      chk("E_op6", {7'd0, o_rsp1, o_rsp0, o_inv, o_out}, {7'd0, 3'b101, 6'd0});
      idle();
      chk("E_red_add", {7'd0, o_rsp1, o_rsp0, o_inv, o_out}, {7'd0, 3'b011, 6'd0});
      idle();
      chk("E_bypass", {7'd0, o_rsp1, o_rsp0, o_inv, o_out}, {7'd0, 3'b011, 6'b111110});
      idle();
      cyc(1'b1, mk(3'd2, 3'd1, 3'd1, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 16'h0, 1'b0);
      do_reset();
      cyc(1'b1, 16'($urandom), 1'b0, 1'b1, 16'($urandom), 1'b0);
      chk("F_no_rsp", {14'd0, o_rsp1, o_rsp0}, 16'd0);
      chk("F_first_grant", 16'(o_rdy0), 16'd1);
      chk("F_lock_clear", 16'(o_lock), 16'd0);
      for (int i = 0; i < 400; i++) begin
         p = (i < 100) ? 80 : (i < 200) ? 25 : (i < 300) ? 95 : 50;
         cyc($urandom_range(0, 99) < p, 16'($urandom), $urandom_range(0, 3) == 0,
             $urandom_range(0, 99) < p, 16'($urandom), $urandom_range(0, 3) == 0);
      end
      idle();
      idle();
      idle();
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
